// File: rtl/uart_out_responder_pkg.sv
// Shared constants, FSM state type and size decode for the UART output responder.
package uart_out_responder_pkg;

    localparam int unsigned LEN_WORD      = 32;
    localparam int unsigned LEN_UART_SIZE = 2;
    // Width of a byte count in the range 1..4
    localparam int unsigned LEN_BYTE_CNT  = 3;

    localparam logic [LEN_UART_SIZE-1:0] UART_SIZE_BYTE = 2'b00;
    localparam logic [LEN_UART_SIZE-1:0] UART_SIZE_HALF = 2'b01;
    localparam logic [LEN_UART_SIZE-1:0] UART_SIZE_WORD = 2'b10;

    typedef enum logic [0:0] {
        StIdle,
        StStall
    } state_e;

    // Bytes carried by a request; the reserved encoding behaves as a word.
    function automatic logic [LEN_BYTE_CNT-1:0] size_to_bytes(
        input logic [LEN_UART_SIZE-1:0] size
    );
        logic [LEN_BYTE_CNT-1:0] n;
        case (size)
            UART_SIZE_BYTE: n = 3'd1;
            UART_SIZE_HALF: n = 3'd2;
            default:        n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with a 1..4 byte write port (LSB first) and a single-byte read port.
module byte_fifo
    import uart_out_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wr_en,
    input  logic [LEN_BYTE_CNT-1:0]   wr_n,
    input  logic [LEN_WORD-1:0]       wr_data,
    input  logic                      rd_en,
    output logic [7:0]                rd_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop;

    // A read on an empty FIFO is ignored
    assign pop = rd_en && (count_q != '0);

    // Next pointers and occupancy; pointers wrap modulo DEPTH naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(wr_n);
            count_d  = count_d + CW'(wr_n);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_d - CW'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage: byte i of the write lands at wr_ptr+i, wrapping around the array
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(wr_n)) begin
                    mem[wr_ptr_q + AW'(i)] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Head byte; forced to zero while empty so the output is clean out of reset
    always_comb begin
        rd_data = 8'h00;
        if (count_q != '0) begin
            rd_data = mem[rd_ptr_q];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/uart_out_responder.sv
// CPU UART output request responder: captures tagged word writes into a byte FIFO
// and streams the bytes to the UART transmitter over valid/ready.
module uart_out_responder
    import uart_out_responder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [LEN_UART_SIZE-1:0] uart_size_in,
    input  logic [LEN_WORD-1:0]      uart_o_data_in,
    input  logic                     uart_write_in,
    input  logic                     uart_order_in,
    output logic                     uart_accepted_out,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_e                  state_q, state_d;
    logic                    last_order_q, last_order_d;
    logic                    accepted_q;
    logic [LEN_BYTE_CNT-1:0] n_bytes;
    logic [CW-1:0]           count;
    logic [CW-1:0]           free;
    logic                    new_req;
    logic                    fits;
    logic                    capture;
    logic                    pop;

    assign n_bytes = size_to_bytes(uart_size_in);
    // Space is judged on the registered count; a same-cycle pop does not help
    assign free    = CW'(FIFO_DEPTH) - count;
    assign fits    = free >= CW'(n_bytes);
    // A request whose tag matches the last capture is already done
    assign new_req = uart_write_in && (uart_order_in != last_order_q);

    // Request FSM: capture when space allows, otherwise wait in StStall
    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        last_order_d = last_order_q;
        unique case (state_q)
            StIdle: begin
                if (new_req) begin
                    if (fits) begin
                        capture = 1'b1;
                    end else begin
                        state_d = StStall;
                    end
                end
            end
            StStall: begin
                if (!new_req) begin
                    state_d = StIdle;
                end else if (fits) begin
                    capture = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (capture) begin
            last_order_d = uart_order_in;
        end
    end

    // FSM state, tag and accept pulse registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            last_order_q <= 1'b0;
            accepted_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_order_q <= last_order_d;
            accepted_q   <= capture;
        end
    end

    assign pop = tx_valid && tx_ready;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (capture),
        .wr_n    (n_bytes),
        .wr_data (uart_o_data_in),
        .rd_en   (pop),
        .rd_data (tx_data),
        .count   (count)
    );

    // Stream and status outputs derive from registered state only
    always_comb begin
        tx_valid          = (count != '0);
        busy              = tx_valid || (state_q == StStall);
        uart_accepted_out = accepted_q;
    end

endmodule

// File: tb/tb_uart_out_responder.sv
// Self-checking bench for uart_out_responder: vector table, hand sequences and
// a byte scoreboard checked at the transmitter handshake.
module tb_uart_out_responder;
    import uart_out_responder_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [1:0]  size = 2'b00;
    logic [31:0] data = '0;
    logic        wr = 1'b0;
    logic        tag = 1'b0;
    logic        ready = 1'b0;
    logic        accepted;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          acc_seen = 0;
    int          a0;
    logic [7:0]  exp_q [$];
    logic [7:0]  exp_b;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] data;
        int          n;
        logic [31:0] bytes;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    uart_out_responder #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .uart_size_in      (size),
        .uart_o_data_in    (data),
        .uart_write_in     (wr),
        .uart_order_in     (tag),
        .uart_accepted_out (accepted),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (ready),
        .busy              (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bytes(input int n, input logic [31:0] b);
        for (int i = 0; i < n; i++) exp_q.push_back(b[8*i +: 8]);
    endtask

    // New-tag write held for one edge; expects capture on that edge
    task automatic write_now(input logic [1:0] s, input logic [31:0] d, input int n,
                             input logic [31:0] b);
        tag  = ~tag;
        size = s;
        data = d;
        wr   = 1'b1;
        push_bytes(n, b);
        step();
        check("accept pulse", 32'(accepted), 1);
        wr = 1'b0;
    endtask

    task automatic drain();
        ready = 1'b1;
        for (int i = 0; i < 64 && tx_valid; i++) step();
        check("drain completes", 32'(tx_valid), 0);
        check("idle after drain", 32'(busy), 0);
        ready = 1'b0;
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        exp_q.delete();
        wr    = 1'b0;
        ready = 1'b0;
        step();
        rstn = 1'b1;
        tag  = 1'b0;
        step();
    endtask

    // Scoreboard: each handshake pops the next expected byte
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (accepted === 1'b1) acc_seen++;
            if (tx_valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stray byte: got 0x%0h, expected none", tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("tx byte order", 32'(tx_data), 32'(exp_b));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00, 32'hDEADBEAB, 1, 32'h000000AB};
        vecs[1] = '{2'b01, 32'h0000CDEF, 2, 32'h0000CDEF};
        vecs[2] = '{2'b10, 32'h44332211, 4, 32'h44332211};
        vecs[3] = '{2'b11, 32'hA5B6C7D8, 4, 32'hA5B6C7D8};
        vecs[4] = '{2'b01, 32'hFFEE1234, 2, 32'h00001234};
        vecs[5] = '{2'b00, 32'h01020380, 1, 32'h00000080};

        // Reset values
        #2 rstn = 1'b0;
        #1;
        check("reset accepted", 32'(accepted), 0);
        check("reset tx_valid", 32'(tx_valid), 0);
        check("reset tx_data", 32'(tx_data), 0);
        check("reset busy", 32'(busy), 0);
        check("reset count", 32'(dut.u_fifo.count_q), 0);
        check("reset state", 32'(dut.state_q), 32'(StIdle));
        step();
        step();
        rstn = 1'b1;
        step();

        // Word write with the transmitter ready: latency and byte cadence
        ready = 1'b1;
        tag   = 1'b1;
        size  = 2'b10;
        data  = 32'h44332211;
        wr    = 1'b1;
        push_bytes(4, 32'h44332211);
        step();
        check("word accept", 32'(accepted), 1);
        check("word first valid", 32'(tx_valid), 1);
        check("word byte0", 32'(tx_data), 32'h11);
        wr = 1'b0;
        step();
        check("accept one cycle", 32'(accepted), 0);
        check("word byte1", 32'(tx_data), 32'h22);
        step();
        step();
        check("word byte3", 32'(tx_data), 32'h44);
        check("busy before last", 32'(busy), 1);
        step();
        check("busy after last", 32'(busy), 0);
        check("empty tx_data", 32'(tx_data), 0);
        ready = 1'b0;

        // Vector table: sizes and byte selection
        foreach (vecs[k]) begin
            write_now(vecs[k].size, vecs[k].data, vecs[k].n, vecs[k].bytes);
            check("vec count", 32'(dut.u_fifo.count_q), 32'(vecs[k].n));
            check("vec head", 32'(tx_data), 32'(vecs[k].bytes[7:0]));
            drain();
        end

        // Held request with unchanged tag captures once; a toggle captures again
        tag  = ~tag;
        size = 2'b10;
        data = 32'h0BADCAFE;
        wr   = 1'b1;
        a0   = acc_seen;
        push_bytes(4, 32'h0BADCAFE);
        repeat (10) step();
        check("held tag accepts", 32'(acc_seen - a0), 1);
        check("held tag count", 32'(dut.u_fifo.count_q), 4);
        tag  = ~tag;
        data = 32'h600DF00D;
        push_bytes(4, 32'h600DF00D);
        step();
        check("toggled tag accept", 32'(accepted), 1);
        check("toggled tag count", 32'(dut.u_fifo.count_q), 8);
        wr = 1'b0;
        drain();

        // Fill to full, then stall until four bytes have left
        for (int i = 0; i < 4; i++) begin
            write_now(2'b10, 32'h10203040 + 32'(i) * 32'h01010101, 4,
                      32'h10203040 + 32'(i) * 32'h01010101);
        end
        check("full count", 32'(dut.u_fifo.count_q), 16);
        tag  = ~tag;
        data = 32'hF1F2F3F4;
        wr   = 1'b1;
        push_bytes(4, 32'hF1F2F3F4);
        step();
        check("full no accept", 32'(accepted), 0);
        check("full stall state", 32'(dut.state_q), 32'(StStall));
        check("stall busy", 32'(busy), 1);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall pops no accept", 32'(accepted), 0);
        end
        check("stall count 13", 32'(dut.u_fifo.count_q), 13);
        step();
        check("fourth pop no accept yet", 32'(accepted), 0);
        check("stall count 12", 32'(dut.u_fifo.count_q), 12);
        ready = 1'b0;
        step();
        check("stall released accept", 32'(accepted), 1);
        check("refill count", 32'(dut.u_fifo.count_q), 16);
        check("back to idle", 32'(dut.state_q), 32'(StIdle));
        wr = 1'b0;
        drain();

        // Simultaneous push and pop across the pointer wrap
        do_reset();
        write_now(2'b10, 32'hA3A2A1A0, 4, 32'hA3A2A1A0);
        write_now(2'b10, 32'hB3B2B1B0, 4, 32'hB3B2B1B0);
        write_now(2'b10, 32'hC3C2C1C0, 4, 32'hC3C2C1C0);
        write_now(2'b01, 32'h9999D1D0, 2, 32'h0000D1D0);
        ready = 1'b1;
        repeat (9) step();
        check("pre-wrap count", 32'(dut.u_fifo.count_q), 5);
        check("pre-wrap wr_ptr", 32'(dut.u_fifo.wr_ptr_q), 14);
        write_now(2'b10, 32'h87654321, 4, 32'h87654321);
        check("push+pop count", 32'(dut.u_fifo.count_q), 8);
        check("wrapped wr_ptr", 32'(dut.u_fifo.wr_ptr_q), 2);
        drain();

        // Asynchronous reset with bytes queued and an accept pulse pending
        write_now(2'b01, 32'h0000BEEF, 2, 32'h0000BEEF);
        tag  = ~tag;
        size = 2'b10;
        data = 32'h11223344;
        wr   = 1'b1;
        step();
        check("pre-reset accept", 32'(accepted), 1);
        check("pre-reset count", 32'(dut.u_fifo.count_q), 6);
        #2 rstn = 1'b0;
        #1;
        check("async reset accepted", 32'(accepted), 0);
        check("async reset tx_valid", 32'(tx_valid), 0);
        check("async reset busy", 32'(busy), 0);
        check("async reset count", 32'(dut.u_fifo.count_q), 0);
        exp_q.delete();
        wr = 1'b0;
        step();
        rstn = 1'b1;
        tag  = 1'b0;
        step();
        write_now(2'b10, 32'hCAFEF00D, 4, 32'hCAFEF00D);
        check("post-reset head", 32'(tx_data), 32'h0D);
        drain();

        check("scoreboard empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
